// File: rtl/mem_responder_pkg.sv
// mem_responder shared types: data width, store widths, FSM states
// and the base lane-mask patterns shifted by mem_lane_gen.
package mem_responder_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      write_byte = 2'd0,
      write_half = 2'd1,
      write_word = 2'd2
   } write_width_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } mem_responder_state_t;

   localparam logic [3:0] LANE_BYTE = 4'b0001;
   localparam logic [3:0] LANE_HALF = 4'b0011;
   localparam logic [3:0] LANE_WORD = 4'b1111;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between hart and mem_responder.
// master = requester (hart), slave = responder.
interface mem_responder_if;
   import mem_responder_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic            req_w_enable;
   logic [XLEN-1:0] req_w_data;
   write_width_t    req_w_width;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_r_data;
   logic            rsp_error;

   modport master (
      output req_valid, req_addr, req_w_enable,
      output req_w_data, req_w_width, rsp_ready,
      input  req_ready, rsp_valid, rsp_r_data, rsp_error
   );

   modport slave (
      input  req_valid, req_addr, req_w_enable,
      input  req_w_data, req_w_width, rsp_ready,
      output req_ready, rsp_valid, rsp_r_data, rsp_error
   );

endinterface

// File: rtl/mem_responder_lane_gen.sv
// mem_lane_gen: combinational store lane mask, lane-replicated write
// data and misalignment flag. Ports: addr_lo, width, data -> mask, w_lanes, misaligned.
module mem_lane_gen
   import mem_responder_pkg::*;
(
   input  logic [1:0]      addr_lo,
   input  write_width_t    width,
   input  logic [XLEN-1:0] data,
   output logic [3:0]      mask,
   output logic [XLEN-1:0] w_lanes,
   output logic            misaligned
);

   always_comb begin
      mask       = '0;
      w_lanes    = '0;
      misaligned = 1'b0;
      unique case (width)
         write_byte: begin
            mask    = LANE_BYTE << addr_lo;
            w_lanes = {4{data[7:0]}};
         end
         write_half: begin
            mask       = LANE_HALF << addr_lo;
            w_lanes    = {2{data[15:0]}};
            misaligned = addr_lo[0];
         end
         write_word: begin
            mask       = LANE_WORD;
            w_lanes    = data;
            misaligned = |addr_lo;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: one load/store per handshake into word RAM, optional
// cycle counter (MEM_RESPONDER_MMIO_EN). Ports: clock, reset, bus (slave).
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h00020000,
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_ADDR   = 32'h00030000
)(
   input logic           clock,
   input logic           reset,
   mem_responder_if.slave bus
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [XLEN-1:0] RAM_END =
      BASE_ADDR + XLEN'(4 * DEPTH_WORDS);

   mem_responder_state_t state, next_state;

   logic [XLEN-1:0] q_addr;
   logic            q_we;
   logic [XLEN-1:0] q_wdata;
   write_width_t    q_width;

   logic [XLEN-1:0] rsp_data_q;
   logic            rsp_err_q;

   logic [XLEN-1:0] ram [DEPTH_WORDS];

   logic            accept;
   logic [3:0]      lane_mask;
   logic [XLEN-1:0] w_lanes;
   logic            misaligned;
   logic            ram_hit;
   logic            mmio_sel;
   logic            mmio_hit;
   logic            err;
   logic            ram_we;
   logic [AW-1:0]   ram_idx;
   logic [XLEN-1:0] rd_word;

   assign accept = bus.req_valid & bus.req_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (accept) next_state = ACCESS;
         ACCESS:  next_state = RESPOND;
         RESPOND: if (bus.rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.rsp_valid  = (state == RESPOND);
   assign bus.rsp_r_data = rsp_data_q;
   assign bus.rsp_error  = rsp_err_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q_addr  <= '0;
         q_we    <= 1'b0;
         q_wdata <= '0;
         q_width <= write_word;
      end else if (accept) begin
         q_addr  <= bus.req_addr;
         q_we    <= bus.req_w_enable;
         q_wdata <= bus.req_w_data;
         q_width <= bus.req_w_width;
      end
   end

   mem_lane_gen u_lane_gen (
      .addr_lo    (q_addr[1:0]),
      .width      (q_width),
      .data       (q_wdata),
      .mask       (lane_mask),
      .w_lanes    (w_lanes),
      .misaligned (misaligned)
   );

   assign ram_hit  = (q_addr >= BASE_ADDR) && (q_addr < RAM_END);
   assign ram_idx  = AW'((q_addr - BASE_ADDR) >> 2);
   assign mmio_sel = (q_addr[XLEN-1:2] == MMIO_ADDR[XLEN-1:2]);

`ifdef MEM_RESPONDER_MMIO_EN
   logic [31:0] counter;
   logic        cnt_load;

   assign mmio_hit = mmio_sel;
   assign cnt_load = (state == ACCESS) & q_we & mmio_hit & ~err;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)        counter <= '0;
      else if (cnt_load) counter <= q_wdata;
      else               counter <= counter + 32'd1;
   end

   assign rd_word = mmio_hit ? counter : ram[ram_idx];
`else
   assign mmio_hit = mmio_sel & 1'b0;
   assign rd_word  = ram[ram_idx];
`endif

   // Counter only accepts full-word stores; narrow ones are faults.
   assign err = ~(ram_hit | mmio_hit)
              | (q_we & misaligned)
              | (q_we & mmio_hit & (q_width != write_word));

   assign ram_we = (state == ACCESS) & q_we & ram_hit & ~err;

   always_ff @(posedge clock) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_mask[i])
               ram[ram_idx][8*i +: 8] <= w_lanes[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else if (state == ACCESS) begin
         rsp_err_q  <= err;
         rsp_data_q <= (err | q_we) ? '0 : rd_word;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
// One task per scenario with inline comparisons.
module tb_mem_responder;
   import mem_responder_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   mem_responder_if bus ();

   mem_responder dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic txn(
      input  logic [31:0] a,
      input  logic        we,
      input  logic [31:0] d,
      input  write_width_t w,
      output logic [31:0] rd,
      output logic        er,
      output int          lat
   );
      int g;
      @(negedge clock);
      bus.req_valid    = 1'b1;
      bus.req_addr     = a;
      bus.req_w_enable = we;
      bus.req_w_data   = d;
      bus.req_w_width  = w;
      g = 0;
      while (!bus.req_ready && g < 20) begin
         @(negedge clock);
         g++;
      end
      @(posedge clock);
      #1;
      bus.req_valid  = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_w_data = 32'hFFFFFFFF;
      lat = 0;
      while (!bus.rsp_valid && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
      end
      if (!bus.rsp_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rsp_timeout addr=%h", a);
      end
      rd = bus.rsp_r_data;
      er = bus.rsp_error;
      bus.rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_cmp++;
      if (bus.rsp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid);
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready);
      end
      n_cmp++;
      if (bus.rsp_r_data !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_rdata got=%h exp=0", bus.rsp_r_data);
      end
      n_cmp++;
      if (bus.rsp_error !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_error got=%b exp=0", bus.rsp_error);
      end
   endtask

   task automatic test_word();
      logic [31:0] rd;
      logic er;
      int lat;
      txn(32'h00020004, 1'b1, 32'hDEADBEEF, write_word, rd, er, lat);
      n_cmp++;
      if (er !== 1'b0 || rd !== 32'h0) begin
         n_bad++;
         $display("FAIL word_store got=%h/%b exp=0/0", rd, er);
      end
      n_cmp++;
      if (lat !== 1) begin
         n_bad++;
         $display("FAIL word_store_lat got=%0d exp=1", lat);
      end
      txn(32'h00020004, 1'b0, 32'h0, write_byte, rd, er, lat);
      n_cmp++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
         n_bad++;
         $display("FAIL word_load got=%h/%b exp=deadbeef/0", rd, er);
      end
      n_cmp++;
      if (lat !== 1) begin
         n_bad++;
         $display("FAIL word_load_lat got=%0d exp=1", lat);
      end
   endtask

   task automatic test_byte();
      logic [31:0] rd;
      logic er;
      int lat;
      txn(32'h00020006, 1'b1, 32'h000000AA, write_byte, rd, er, lat);
      n_cmp++;
      if (er !== 1'b0) begin
         n_bad++;
         $display("FAIL byte_store_err got=%b exp=0", er);
      end
      txn(32'h00020004, 1'b0, 32'h0, write_word, rd, er, lat);
      n_cmp++;
      if (rd !== 32'hDEAABEEF || er !== 1'b0) begin
         n_bad++;
         $display("FAIL byte_load got=%h/%b exp=deaabeef/0", rd, er);
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] rd;
      logic er;
      int lat;
      txn(32'h00020000, 1'b1, 32'h11223344, write_word, rd, er, lat);
      txn(32'h00020003, 1'b1, 32'h0000BBCC, write_half, rd, er, lat);
      n_cmp++;
      if (er !== 1'b1 || rd !== 32'h0) begin
         n_bad++;
         $display("FAIL mis_half got=%h/%b exp=0/1", rd, er);
      end
      txn(32'h00020002, 1'b1, 32'h99999999, write_word, rd, er, lat);
      n_cmp++;
      if (er !== 1'b1) begin
         n_bad++;
         $display("FAIL mis_word got=%b exp=1", er);
      end
      txn(32'h00020000, 1'b0, 32'h0, write_word, rd, er, lat);
      n_cmp++;
      if (rd !== 32'h11223344 || er !== 1'b0) begin
         n_bad++;
         $display("FAIL mis_unchanged got=%h/%b exp=11223344/0", rd, er);
      end
      txn(32'h00020003, 1'b0, 32'h0, write_word, rd, er, lat);
      n_cmp++;
      if (rd !== 32'h11223344 || er !== 1'b0) begin
         n_bad++;
         $display("FAIL mis_load got=%h/%b exp=11223344/0", rd, er);
      end
   endtask

   task automatic test_half();
      logic [31:0] rd;
      logic er;
      int lat;
      txn(32'h00020002, 1'b1, 32'hFFFF5566, write_half, rd, er, lat);
      n_cmp++;
      if (er !== 1'b0) begin
         n_bad++;
         $display("FAIL half_store_err got=%b exp=0", er);
      end
      txn(32'h00020000, 1'b0, 32'h0, write_word, rd, er, lat);
      n_cmp++;
      if (rd !== 32'h55663344) begin
         n_bad++;
         $display("FAIL half_load got=%h exp=55663344", rd);
      end
   endtask

   task automatic test_decode();
      logic [31:0] rd;
      logic er;
      int lat;
      txn(32'h00010000, 1'b0, 32'h0, write_word, rd, er, lat);
      n_cmp++;
      if (er !== 1'b1 || rd !== 32'h0) begin
         n_bad++;
         $display("FAIL dec_below got=%h/%b exp=0/1", rd, er);
      end
      txn(32'h00021000, 1'b0, 32'h0, write_word, rd, er, lat);
      n_cmp++;
      if (er !== 1'b1) begin
         n_bad++;
         $display("FAIL dec_past_end got=%b exp=1", er);
      end
      txn(32'h0001FFFC, 1'b0, 32'h0, write_word, rd, er, lat);
      n_cmp++;
      if (er !== 1'b1) begin
         n_bad++;
         $display("FAIL dec_before_base got=%b exp=1", er);
      end
      txn(32'h00020FFC, 1'b1, 32'hCAFEF00D, write_word, rd, er, lat);
      txn(32'h00020FFC, 1'b0, 32'h0, write_word, rd, er, lat);
      n_cmp++;
      if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
         n_bad++;
         $display("FAIL dec_last_word got=%h/%b exp=cafef00d/0", rd, er);
      end
      txn(32'h00021000, 1'b1, 32'h12345678, write_word, rd, er, lat);
      n_cmp++;
      if (er !== 1'b1) begin
         n_bad++;
         $display("FAIL dec_store_miss got=%b exp=1", er);
      end
   endtask

   task automatic test_stall_and_reset();
      logic [31:0] rd;
      logic er;
      int lat;
      @(negedge clock);
      bus.req_valid    = 1'b1;
      bus.req_addr     = 32'h00020004;
      bus.req_w_enable = 1'b0;
      bus.req_w_width  = write_word;
      @(posedge clock);
      #1;
      bus.req_w_enable = 1'b1;
      bus.req_w_data   = 32'h0;
      @(posedge clock);
      #1;
      n_cmp++;
      if (bus.rsp_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL stall_rsp_start got=%b exp=1", bus.rsp_valid);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #1;
         n_cmp++;
         if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
             bus.rsp_r_data !== 32'hDEAABEEF) begin
            n_bad++;
            $display("FAIL stall_hold%0d got=%b/%b/%h exp=1/0/deaabeef",
                     i, bus.rsp_valid, bus.req_ready, bus.rsp_r_data);
         end
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      bus.rsp_ready = 1'b0;
      n_cmp++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL stall_release got=%b/%b exp=1/0",
                  bus.req_ready, bus.rsp_valid);
      end
      txn(32'h00020004, 1'b0, 32'h0, write_word, rd, er, lat);
      n_cmp++;
      if (rd !== 32'hDEAABEEF) begin
         n_bad++;
         $display("FAIL stall_no_reaccept got=%h exp=deaabeef", rd);
      end

      @(negedge clock);
      bus.req_valid    = 1'b1;
      bus.req_addr     = 32'h00020004;
      bus.req_w_enable = 1'b0;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clock);
      #1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      n_cmp++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_r_data !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_mid_rsp got=%b/%h exp=0/0",
                  bus.rsp_valid, bus.rsp_r_data);
      end
      @(negedge clock);
      reset = 1'b1;

      @(negedge clock);
      bus.req_valid    = 1'b1;
      bus.req_addr     = 32'h00020004;
      bus.req_w_enable = 1'b1;
      bus.req_w_data   = 32'h0BADF00D;
      bus.req_w_width  = write_word;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;

      txn(32'h00020004, 1'b0, 32'h0, write_word, rd, er, lat);
      n_cmp++;
      if (rd !== 32'hDEAABEEF || er !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_drop_store got=%h/%b exp=deaabeef/0", rd, er);
      end
      n_cmp++;
      if (lat !== 1) begin
         n_bad++;
         $display("FAIL post_reset_lat got=%0d exp=1", lat);
      end
   endtask

   task automatic test_mmio();
      logic [31:0] rd;
      logic er;
      int lat;
`ifdef MEM_RESPONDER_MMIO_EN
      txn(32'h00030000, 1'b1, 32'hFFFFFFFE, write_word, rd, er, lat);
      n_cmp++;
      if (er !== 1'b0) begin
         n_bad++;
         $display("FAIL mmio_store_err got=%b exp=0", er);
      end
      txn(32'h00030000, 1'b0, 32'h0, write_word, rd, er, lat);
      n_cmp++;
      if (er !== 1'b0 || rd >= 32'd10) begin
         n_bad++;
         $display("FAIL mmio_wrap got=%h/%b exp=<10/0", rd, er);
      end
      txn(32'h00030000, 1'b1, 32'h5, write_byte, rd, er, lat);
      n_cmp++;
      if (er !== 1'b1) begin
         n_bad++;
         $display("FAIL mmio_byte got=%b exp=1", er);
      end
`else
      txn(32'h00030000, 1'b0, 32'h0, write_word, rd, er, lat);
      n_cmp++;
      if (er !== 1'b1 || rd !== 32'h0) begin
         n_bad++;
         $display("FAIL mmio_absent got=%h/%b exp=0/1", rd, er);
      end
`endif
   endtask

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_addr     = '0;
      bus.req_w_enable = 1'b0;
      bus.req_w_data   = '0;
      bus.req_w_width  = write_word;
      bus.rsp_ready    = 1'b0;
      test_reset();
      test_word();
      test_byte();
      test_misaligned();
      test_half();
      test_decode();
      test_stall_and_reset();
      test_mmio();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
